// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word width, RAM handshake states, and the
// memory arbiter's FSM state and bus-owner encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a single RAM port between instruction fetch and data access,
// with data priority, bounded instruction starvation and a grant timeout.
//
// state  | meaning
// IDLE   | no held grant; owner is the combinational winner this cycle
// BUSY_I | instruction fetch holds the RAM, waiting for ACCESS
// BUSY_D | data access holds the RAM, waiting for ACCESS
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      tmo_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    arb_state_t    state;
    logic [CW-1:0] cycle_cnt;
    logic [SW-1:0] starve_cnt;
    logic          tmo_flag;

    owner_t owner;
    logic   d_req;
    logic   own_req;
    logic   access;
    logic   fail;
    logic   i_done;
    logic   d_done;

    // Owner is forced to none during reset so enables drop immediately.
    always_comb begin
        d_req = dREN | dWEN;
        owner = OWN_NONE;
        if (!RST) begin
            case (state)
                BUSY_I:  owner = OWN_I;
                BUSY_D:  owner = OWN_D;
                default: begin
                    if (iREN && (starve_cnt == STARVE_TOP))
                        owner = OWN_I;
                    else if (d_req)
                        owner = OWN_D;
                    else if (iREN)
                        owner = OWN_I;
                end
            endcase
        end
    end

    always_comb begin
        access  = (ramstate == ACCESS);
        own_req = 1'b0;
        case (owner)
            OWN_I:   own_req = iREN;
            OWN_D:   own_req = d_req;
            default: own_req = 1'b0;
        endcase
        i_done = (owner == OWN_I) && own_req && access;
        d_done = (owner == OWN_D) && own_req && access;
        // A withdrawn request is an abort, never a timeout or error.
        fail   = own_req && !access &&
                 ((ramstate == ERROR) || ((state != IDLE) && (cycle_cnt == CNT_LAST)));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cycle_cnt  <= '0;
            starve_cnt <= '0;
            tmo_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cycle_cnt <= '0;
                    if (own_req && !access && !fail)
                        state <= (owner == OWN_I) ? BUSY_I : BUSY_D;
                end
                default: begin
                    if (!own_req || access || fail) begin
                        state     <= IDLE;
                        cycle_cnt <= '0;
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
            endcase

            if (fail)
                tmo_flag <= 1'b1;

            if (!iREN || i_done)
                starve_cnt <= '0;
            else if (d_done && (starve_cnt != STARVE_TOP))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (owner)
            OWN_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
            end
            OWN_I: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
            end
            default: ;
        endcase
        iload   = ramload;
        dload   = ramload;
        iwait   = iREN & ~((owner == OWN_I) & access);
        dwait   = d_req & ~((owner == OWN_D) & access);
        tmo_err = tmo_flag;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: priority, starvation limit, writes,
// error/timeout recovery and asynchronous reset mid-transaction.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    logic      iwait, dwait, ramREN, ramWEN, tmo_err;
    word_t     iload, dload, ramaddr, ramstore;
    ramstate_t ramstate;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .tmo_err(tmo_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h40; daddr = 32'h100; dstore = 32'h0;
        ramload = 32'h1234_5678; ramstate = BUSY;
        #2;
        chk("rst_ramren", ramREN, 0);
        chk("rst_ramwen", ramWEN, 0);
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_tmo", tmo_err, 0);
        chk("rst_addr", ramaddr, 0);
        chk("load_i", iload, 32'h1234_5678);
        chk("load_d", dload, 32'h1234_5678);

        // Data beats instruction; ACCESS on the third owned cycle
        tick(); RST = 1'b0; #1;
        chk("c1_addr", ramaddr, 32'h100);
        chk("c1_ren", ramREN, 1);
        chk("c1_dwait", dwait, 1);
        chk("c1_iwait", iwait, 1);
        tick();
        chk("c2_state", dut.state, BUSY_D);
        chk("c2_addr", ramaddr, 32'h100);
        tick(); ramstate = ACCESS; #1;
        chk("c3_dwait", dwait, 0);
        chk("c3_iwait", iwait, 1);
        tick(); dREN = 1'b0; #1;
        chk("c4_state", dut.state, IDLE);
        chk("c4_starve", dut.starve_cnt, 1);
        chk("c4_addr", ramaddr, 32'h40);
        chk("c4_iwait", iwait, 0);
        chk("c4_wen", ramWEN, 0);

        // Starvation limit: four data completions, then instruction wins
        tick(); iaddr = 32'h80; dREN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            daddr = 32'h200 + k; #1;
            chk("st_addr", ramaddr, 32'h200 + k);
            chk("st_dwait", dwait, 0);
            chk("st_iwait", iwait, 1);
            tick();
        end
        chk("st_cnt4", dut.starve_cnt, 4);
        chk("st5_addr", ramaddr, 32'h80);
        chk("st5_iwait", iwait, 0);
        chk("st5_dwait", dwait, 1);
        tick();
        chk("st_clr", dut.starve_cnt, 0);
        chk("st6_addr", ramaddr, 32'h203);

        // Read+write together is a write
        iREN = 1'b0; dWEN = 1'b1; daddr = 32'h300; dstore = 32'hDEAD_BEEF; #1;
        chk("wr_wen", ramWEN, 1);
        chk("wr_ren", ramREN, 0);
        chk("wr_store", ramstore, 32'hDEAD_BEEF);
        chk("wr_addr", ramaddr, 32'h300);
        chk("wr_dwait", dwait, 0);
        tick(); dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; #1;
        chk("none_addr", ramaddr, 0);
        chk("none_store", ramstore, 0);
        chk("none_ren", ramREN, 0);

        // Reset pulse during BUSY_D, then abort on request drop
        tick(); dREN = 1'b1; daddr = 32'h500; ramstate = BUSY;
        tick(); tick();
        chk("rb_state", dut.state, BUSY_D);
        chk("rb_cnt", dut.cycle_cnt, 1);
        RST = 1'b1; #1;
        chk("rb_ren", ramREN, 0);
        chk("rb_idle", dut.state, IDLE);
        chk("rb_cnt0", dut.cycle_cnt, 0);
        chk("rb_dwait", dwait, 1);
        tick(); RST = 1'b0; #1;
        chk("rb_regrant", ramREN, 1);
        chk("rb_readdr", ramaddr, 32'h500);
        tick();
        chk("rb_busy", dut.state, BUSY_D);
        dREN = 1'b0;
        tick();
        chk("abort_idle", dut.state, IDLE);
        chk("abort_tmo", tmo_err, 0);

        // ERROR during BUSY_D
        dREN = 1'b1; daddr = 32'h400;
        tick();
        ramstate = ERROR; #1;
        chk("er_dwait", dwait, 1);
        chk("er_tmo0", tmo_err, 0);
        tick(); ramstate = BUSY; #1;
        chk("er_state", dut.state, IDLE);
        chk("er_tmo1", tmo_err, 1);
        chk("er_dwait2", dwait, 1);
        dREN = 1'b0;
        tick(); RST = 1'b1; #1;
        tick(); RST = 1'b0; #1;
        chk("er_rstclr", tmo_err, 0);

        // Timeout on an instruction grant
        iREN = 1'b1; iaddr = 32'h40;
        tick();
        chk("to_busy", dut.state, BUSY_I);
        for (int k = 0; k < 63; k++) tick();
        chk("to_last", dut.cycle_cnt, 63);
        chk("to_tmo0", tmo_err, 0);
        tick();
        chk("to_idle", dut.state, IDLE);
        chk("to_tmo1", tmo_err, 1);
        chk("to_iwait", iwait, 1);
        chk("to_regrant", ramREN, 1);
        chk("to_addr", ramaddr, 32'h40);
        tick();
        chk("to_rebusy", dut.state, BUSY_I);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
